// File: rtl/cpu_pkg.sv
// Shared types for the writeback stage: op encoding, FSM states, default widths.
package cpu_pkg;

  localparam int unsigned W_DEF = 8;
  localparam int unsigned D_DEF = 3;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_ALU   = 3'd1,
    OP_LDI   = 3'd2,
    OP_CLR   = 3'd3,
    OP_INC   = 3'd4,
    OP_GETOV = 3'd5,
    OP_LOAD  = 3'd6,
    OP_RSVD  = 3'd7
  } wb_op_t;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/reg_writeback.sv
// Writeback stage: turns execute requests into single-cycle register file strobes,
// owns the overflow flag and waits (with timeout) on data memory for loads.
module reg_writeback
  import cpu_pkg::*;
#(
  parameter int unsigned W           = W_DEF,
  parameter int unsigned D           = D_DEF,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic         CLK,
  input  logic         Reset_n,
  input  logic         WbValid,
  output logic         WbReady,
  input  logic [2:0]   WbOp,
  input  logic [D-1:0] WbDest,
  input  logic [W-1:0] WbData,
  input  logic         OvUpdate,
  input  logic         AluOv,
  input  logic [W-1:0] MemRdData,
  input  logic         MemRdValid,
  output logic         RegWrite,
  output logic         ClearReg,
  output logic         IncReg,
  output logic         OvToReg,
  output logic         LoadImm,
  output logic [D-1:0] writeReg,
  output logic [W-1:0] writeValue,
  output logic         ovValue,
  output logic         OvFlag,
  output logic         MemErr,
  output logic         Busy
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  wb_state_t      state_q, state_d;
  logic [D-1:0]   dest_q, dest_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ov_flag_q, ov_flag_d;
  logic           mem_err_q, mem_err_d;
  logic           reg_write_q, reg_write_d;
  logic           clear_reg_q, clear_reg_d;
  logic           inc_reg_q, inc_reg_d;
  logic           ov_to_reg_q, ov_to_reg_d;
  logic           load_imm_q, load_imm_d;
  logic [D-1:0]   write_reg_q, write_reg_d;
  logic [W-1:0]   write_value_q, write_value_d;
  logic           ov_value_q, ov_value_d;

  wb_op_t op;
  logic   accept;

  assign op      = wb_op_t'(WbOp);
  assign accept  = WbValid && (state_q == S_IDLE);

  always_comb begin
    state_d       = state_q;
    dest_d        = dest_q;
    cnt_d         = cnt_q;
    ov_flag_d     = ov_flag_q;
    mem_err_d     = mem_err_q;
    reg_write_d   = 1'b0;
    clear_reg_d   = 1'b0;
    inc_reg_d     = 1'b0;
    ov_to_reg_d   = 1'b0;
    load_imm_d    = 1'b0;
    write_reg_d   = '0;
    write_value_d = '0;
    ov_value_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (OvUpdate) ov_flag_d = AluOv;
          case (op)
            OP_ALU: begin
              reg_write_d   = 1'b1;
              write_reg_d   = WbDest;
              write_value_d = WbData;
            end
            OP_LDI: begin
              reg_write_d   = 1'b1;
              load_imm_d    = 1'b1;
              write_value_d = WbData;
            end
            OP_CLR: begin
              reg_write_d = 1'b1;
              clear_reg_d = 1'b1;
              write_reg_d = WbDest;
            end
            OP_INC: begin
              reg_write_d = 1'b1;
              inc_reg_d   = 1'b1;
              write_reg_d = WbDest;
            end
            OP_GETOV: begin
              // Reports the flag as it stood before this request's own update.
              reg_write_d = 1'b1;
              ov_to_reg_d = 1'b1;
              write_reg_d = WbDest;
              ov_value_d  = ov_flag_q;
            end
            OP_LOAD: begin
              dest_d  = WbDest;
              cnt_d   = '0;
              state_d = S_WAIT_MEM;
            end
            default: ;
          endcase
        end
      end
      S_WAIT_MEM: begin
        if (MemRdValid) begin
          reg_write_d   = 1'b1;
          write_reg_d   = dest_q;
          write_value_d = MemRdData;
          state_d       = S_IDLE;
        end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
          // This miss would bring the count to MEM_TIMEOUT: give up on the load.
          mem_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q       <= S_IDLE;
      dest_q        <= '0;
      cnt_q         <= '0;
      ov_flag_q     <= 1'b0;
      mem_err_q     <= 1'b0;
      reg_write_q   <= 1'b0;
      clear_reg_q   <= 1'b0;
      inc_reg_q     <= 1'b0;
      ov_to_reg_q   <= 1'b0;
      load_imm_q    <= 1'b0;
      write_reg_q   <= '0;
      write_value_q <= '0;
      ov_value_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dest_q        <= dest_d;
      cnt_q         <= cnt_d;
      ov_flag_q     <= ov_flag_d;
      mem_err_q     <= mem_err_d;
      reg_write_q   <= reg_write_d;
      clear_reg_q   <= clear_reg_d;
      inc_reg_q     <= inc_reg_d;
      ov_to_reg_q   <= ov_to_reg_d;
      load_imm_q    <= load_imm_d;
      write_reg_q   <= write_reg_d;
      write_value_q <= write_value_d;
      ov_value_q    <= ov_value_d;
    end
  end

  assign WbReady    = (state_q == S_IDLE);
  assign Busy       = (state_q == S_WAIT_MEM);
  assign RegWrite   = reg_write_q;
  assign ClearReg   = clear_reg_q;
  assign IncReg     = inc_reg_q;
  assign OvToReg    = ov_to_reg_q;
  assign LoadImm    = load_imm_q;
  assign writeReg   = write_reg_q;
  assign writeValue = write_value_q;
  assign ovValue    = ov_value_q;
  assign OvFlag     = ov_flag_q;
  assign MemErr     = mem_err_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback with a behavioural register file downstream.
module tb_reg_writeback;

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic       WbValid = 1'b0;
  logic       WbReady;
  logic [2:0] WbOp = 3'd0;
  logic [2:0] WbDest = 3'd0;
  logic [7:0] WbData = 8'd0;
  logic       OvUpdate = 1'b0;
  logic       AluOv = 1'b0;
  logic [7:0] MemRdData = 8'd0;
  logic       MemRdValid = 1'b0;
  logic       RegWrite, ClearReg, IncReg, OvToReg, LoadImm;
  logic [2:0] writeReg;
  logic [7:0] writeValue;
  logic       ovValue, OvFlag, MemErr, Busy;

  reg_writeback #(.W(8), .D(3), .MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .WbValid(WbValid), .WbReady(WbReady),
    .WbOp(WbOp), .WbDest(WbDest), .WbData(WbData), .OvUpdate(OvUpdate),
    .AluOv(AluOv), .MemRdData(MemRdData), .MemRdValid(MemRdValid),
    .RegWrite(RegWrite), .ClearReg(ClearReg), .IncReg(IncReg),
    .OvToReg(OvToReg), .LoadImm(LoadImm), .writeReg(writeReg),
    .writeValue(writeValue), .ovValue(ovValue), .OvFlag(OvFlag),
    .MemErr(MemErr), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rw, clr, inc, ovr, ldi;
    logic [2:0] wreg;
    logic [7:0] wval;
    logic       ov;
    logic       chk_val;
    logic       chk_ov;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rf[8];
  logic       m_ov = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe cycle and plays the register file.
  initial begin
    exp_t e;
    logic any;
    forever begin
      @(posedge CLK);
      #1;
      any = RegWrite | ClearReg | IncReg | OvToReg | LoadImm;
      if (any) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got rw%b clr%b inc%b ovr%b ldi%b reg%0d val 0x%0h expected no strobe at %0t",
                   RegWrite, ClearReg, IncReg, OvToReg, LoadImm, writeReg, writeValue, $time);
        end else begin
          e = sb.pop_front();
          chk("strobe_flags", {27'd0, RegWrite, ClearReg, IncReg, OvToReg, LoadImm},
              {27'd0, e.rw, e.clr, e.inc, e.ovr, e.ldi});
          chk("write_reg", {29'd0, writeReg}, {29'd0, e.wreg});
          if (e.chk_val) chk("write_value", {24'd0, writeValue}, {24'd0, e.wval});
          if (e.chk_ov) chk("ov_value", {31'd0, ovValue}, {31'd0, e.ov});
        end
        if (RegWrite) begin
          if (ClearReg)     rf[writeReg] = 8'h00;
          else if (IncReg)  rf[writeReg] = rf[writeReg] + 8'h01;
          else if (OvToReg) rf[writeReg][7] = ovValue;
          else              rf[writeReg] = writeValue;
        end
      end else begin
        chk("idle_outputs_zero", {20'd0, writeReg, writeValue, ovValue}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] dest, input logic [7:0] data,
                       input logic ovu, input logic aov);
    exp_t e;
    @(negedge CLK);
    chk("ready_before_issue", {31'd0, WbReady}, 32'd1);
    WbValid = 1'b1; WbOp = op; WbDest = dest; WbData = data; OvUpdate = ovu; AluOv = aov;
    e = '0;
    case (op)
      3'd1: begin e.rw = 1; e.wreg = dest; e.wval = data; e.chk_val = 1; end
      3'd2: begin e.rw = 1; e.ldi = 1; e.wreg = 3'd0; e.wval = data; e.chk_val = 1; end
      3'd3: begin e.rw = 1; e.clr = 1; e.wreg = dest; end
      3'd4: begin e.rw = 1; e.inc = 1; e.wreg = dest; end
      3'd5: begin e.rw = 1; e.ovr = 1; e.wreg = dest; e.ov = m_ov; e.chk_ov = 1; end
      default: ;
    endcase
    if (op >= 3'd1 && op <= 3'd5) sb.push_back(e);
    if (ovu) m_ov = aov;
    @(posedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      WbValid = 1'b0; OvUpdate = 1'b0; MemRdValid = 1'b0;
    end
  endtask

  task automatic mem_return(input logic [2:0] dest, input logic [7:0] data);
    exp_t e;
    e = '0; e.rw = 1; e.wreg = dest; e.wval = data; e.chk_val = 1;
    sb.push_back(e);
    MemRdValid = 1'b1; MemRdData = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    logic done;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;

    // Power-on reset
    repeat (2) @(negedge CLK);
    chk("rst_strobes", {27'd0, RegWrite, ClearReg, IncReg, OvToReg, LoadImm}, 32'd0);
    chk("rst_flags", {29'd0, OvFlag, MemErr, Busy}, 32'd0);
    chk("rst_ready", {31'd0, WbReady}, 32'd1);
    Reset_n = 1'b1;

    // Back-to-back ALU, LDI (dest ignored), INC
    issue(3'd1, 3'd3, 8'h5A, 1'b0, 1'b0);
    issue(3'd2, 3'd5, 8'h11, 1'b0, 1'b0);
    issue(3'd4, 3'd3, 8'h00, 1'b0, 1'b0);
    idle(2);
    chk("r3_after_inc", {24'd0, rf[3]}, 32'h5B);
    chk("r0_after_ldi", {24'd0, rf[0]}, 32'h11);
    chk("r5_untouched", {24'd0, rf[5]}, 32'h00);
    issue(3'd3, 3'd3, 8'hFF, 1'b0, 1'b0);
    idle(2);
    chk("r3_after_clr", {24'd0, rf[3]}, 32'h00);

    // Overflow flag and GETOV
    issue(3'd1, 3'd2, 8'h05, 1'b1, 1'b1);
    issue(3'd5, 3'd2, 8'h00, 1'b0, 1'b0);
    issue(3'd5, 3'd6, 8'h00, 1'b1, 1'b0);
    idle(2);
    chk("r2_after_getov", {24'd0, rf[2]}, 32'h85);
    chk("r6_after_getov", {24'd0, rf[6]}, 32'h80);
    chk("ovflag_cleared", {31'd0, OvFlag}, 32'd0);

    // LOAD with data after 3 empty wait cycles
    issue(3'd6, 3'd4, 8'h00, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); WbValid = 1'b0;
      if (!WbReady) cnt++;
    end
    @(negedge CLK); WbValid = 1'b0;
    if (!WbReady) cnt++;
    chk("busy_in_wait", {31'd0, Busy}, 32'd1);
    mem_return(3'd4, 8'hC3);
    @(negedge CLK); MemRdValid = 1'b0;
    chk("load_ready_low_cycles", cnt, 32'd4);
    chk("ready_after_load", {31'd0, WbReady}, 32'd1);
    idle(1);
    chk("r4_after_load", {24'd0, rf[4]}, 32'hC3);

    // LOAD timeout
    issue(3'd6, 3'd1, 8'h00, 1'b0, 1'b0);
    cnt = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK); WbValid = 1'b0;
      if (WbReady) done = 1'b1; else cnt++;
    end
    chk("timeout_returned", {31'd0, done}, 32'd1);
    chk("timeout_wait_cycles", cnt, 32'd15);
    chk("memerr_set", {31'd0, MemErr}, 32'd1);
    chk("r1_no_write", {24'd0, rf[1]}, 32'h00);
    issue(3'd1, 3'd1, 8'h3C, 1'b0, 1'b0);
    idle(2);
    chk("r1_after_alu", {24'd0, rf[1]}, 32'h3C);
    chk("memerr_sticky", {31'd0, MemErr}, 32'd1);

    // Reserved op held, memory pulse while idle
    @(negedge CLK);
    WbValid = 1'b1; WbOp = 3'd7; WbDest = 3'd2; WbData = 8'hEE; OvUpdate = 1'b0;
    MemRdValid = 1'b1; MemRdData = 8'hFF;
    @(negedge CLK); MemRdValid = 1'b0;
    @(negedge CLK);
    chk("op7_ready", {31'd0, WbReady}, 32'd1);
    chk("op7_not_busy", {31'd0, Busy}, 32'd0);
    idle(1);
    chk("r2_after_op7", {24'd0, rf[2]}, 32'h85);

    // NONE with OvUpdate, then reset in the middle of a LOAD
    issue(3'd0, 3'd0, 8'h00, 1'b1, 1'b1);
    idle(1);
    chk("none_sets_ov", {31'd0, OvFlag}, 32'd1);
    issue(3'd6, 3'd5, 8'h00, 1'b0, 1'b0);
    idle(2);
    @(negedge CLK); Reset_n = 1'b0; WbValid = 1'b0;
    @(negedge CLK);
    @(negedge CLK); Reset_n = 1'b1; m_ov = 1'b0;
    chk("midrst_ready", {31'd0, WbReady}, 32'd1);
    chk("midrst_flags", {29'd0, OvFlag, MemErr, Busy}, 32'd0);
    chk("midrst_strobes", {27'd0, RegWrite, ClearReg, IncReg, OvToReg, LoadImm}, 32'd0);
    MemRdValid = 1'b1; MemRdData = 8'hAA;
    @(negedge CLK); MemRdValid = 1'b0;
    idle(1);
    chk("r5_aborted_load", {24'd0, rf[5]}, 32'h00);

    // MemRdValid on the timeout cycle itself wins
    issue(3'd6, 3'd7, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK); WbValid = 1'b0;
    end
    @(negedge CLK);
    mem_return(3'd7, 8'h7E);
    @(negedge CLK); MemRdValid = 1'b0;
    chk("edge_no_memerr", {31'd0, MemErr}, 32'd0);
    chk("edge_ready", {31'd0, WbReady}, 32'd1);
    idle(1);
    chk("r7_edge_load", {24'd0, rf[7]}, 32'h7E);

    idle(3);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
Writeback stage that sits directly upstream of the 8-entry register file. It accepts one writeback request per cycle from execute via a valid/ready handshake and holds the architectural overflow flag. It waits for data memory on loads, with a timeout. It then drives the register file write port with exactly one single-cycle strobe pattern per request.

Parameters:
W, 8, data width of register values
D, 3, register address width (2**D registers)
MEM_TIMEOUT, 15, max cycles waited for MemRdValid after a LOAD is accepted

Ports:
CLK  in  1  clock, all state updates on posedge
Reset_n  in  1  synchronous active-low reset
WbValid  in  1  execute presents a request
WbReady  out  1  stage can accept; combinational, equals (state==S_IDLE)
WbOp  in  3  wb_op_t: NONE=0, ALU=1, LDI=2, CLR=3, INC=4, GETOV=5, LOAD=6 (7 treated as NONE)
WbDest  in  D  destination register
WbData  in  W  ALU result or immediate
OvUpdate  in  1  request updates overflow flag
AluOv  in  1  new overflow value
MemRdData  in  W  data memory read data
MemRdValid  in  1  MemRdData valid this cycle
RegWrite, ClearReg, IncReg, OvToReg, LoadImm  out  1 each  register file strobes (registered)
writeReg  out  D  register file write address (registered)
writeValue  out  W  register file write data (registered)
ovValue  out  1  overflow bit for GETOV (registered)
OvFlag  out  1  current architectural overflow flag
MemErr  out  1  sticky load-timeout error
Busy  out  1  high in S_WAIT_MEM

Behaviour:
- Reset is synchronous, active-low and dominant. On reset, all outputs are 0, OvFlag=0, MemErr=0, state=S_IDLE, wait counter=0.
- Reset in S_WAIT_MEM aborts the load with no write.
- Accept = WbValid && WbReady, sampled at posedge t. Strobes are high for the cycle t..t+1 only; the register file commits at posedge t+1.
- Back-to-back non-LOAD requests are accepted every cycle.
- Strobe encoding on accept:
  - ALU: RegWrite; writeReg=WbDest; writeValue=WbData.
  - LDI: RegWrite+LoadImm; writeReg forced to 0; writeValue=WbData.
  - CLR: RegWrite+ClearReg; writeReg=WbDest.
  - INC: RegWrite+IncReg; writeReg=WbDest.
  - GETOV: RegWrite+OvToReg; writeReg=WbDest; ovValue=OvFlag (value before any same-cycle update).
  - NONE and code 7: no strobes.
- Never more than one of ClearReg/IncReg/OvToReg/LoadImm is high. None of them is high without RegWrite.
- Cycles with no strobe: writeReg, writeValue and ovValue are driven to 0.
- Overflow flag: on accept with OvUpdate=1, OvFlag <= AluOv at the same edge, for any op including NONE and LOAD. There are no other writers.
- State machine:
  - S_IDLE: on accepting LOAD, latch WbDest, clear the counter, go to S_WAIT_MEM, and issue no strobe.
  - S_IDLE: MemRdValid is ignored.
  - S_WAIT_MEM: WbReady=0.
  - S_WAIT_MEM, MemRdValid=1: next cycle RegWrite with writeReg=latched dest and writeValue=MemRdData; return to S_IDLE. The earliest MemRdValid is 1 cycle after accept.
  - S_WAIT_MEM, MemRdValid=0: counter++.
  - Counter reaches MEM_TIMEOUT while MemRdValid=0: MemErr<=1, no write, return to S_IDLE. MemRdValid on the timeout cycle itself wins (the write happens, no error).
- MemErr is cleared only by reset. It does not block further requests.
- Counter width is $clog2(MEM_TIMEOUT+1). Counter saturation is impossible by construction.
- The stage performs no arithmetic. INC and CLR are delegated to the register file.

Decomposition:
- cpu_pkg holds wb_op_t (3-bit enum above), the W/D defaults, and the state enum wb_state_t {S_IDLE, S_WAIT_MEM}.
- Single module; no sub-module. The timeout counter is inline logic.

Test Plan:
- Reset_n=0 for 2 cycles mid-stream, including during S_WAIT_MEM -> all strobes, OvFlag and MemErr are 0, WbReady=1, and no register changes.
- ALU r3=0x5A, then LDI 0x11, then INC r3 on consecutive cycles -> three consecutive strobe cycles. Final state r3=0x5B, r0=0x11. LDI shows writeReg=0 even with WbDest=5.
- ALU with OvUpdate=1, AluOv=1, then GETOV r2 (r2=0x05) -> ovValue=1 and r2=0x85. GETOV with a same-cycle OvUpdate AluOv=0 still reports 1, and OvFlag is 0 afterwards.
- LOAD r4, MemRdValid after 3 cycles with 0xC3 -> WbReady low for 4 cycles, a single RegWrite with writeReg=4, writeValue=0xC3, and r4=0xC3.
- LOAD r1 with no MemRdValid for MEM_TIMEOUT cycles -> MemErr=1, no write, return to S_IDLE. The next ALU request completes normally.
- WbValid held with WbOp=7 and MemRdValid pulsed in S_IDLE -> no strobes and no state change.
